// File: rtl/cv_num2text.sv
// cv_num2text
//   Formats a binary pulse-generator quantity into the 12-character ASCII
//   string used by the on-screen renderer: 4-char label, 6 decimal digits,
//   2-char unit. Binary-to-BCD is a serial double-dabble, one bit per clock.
//   text_out only changes on completion, so the renderer never sees a
//   half-converted string.
//
// Ports
//   clk, reset        clock (rising edge), synchronous active-high reset
//   en                block enable; low aborts a conversion in progress
//   start             conversion request, sampled only while idle
//   value             unsigned binary input
//   label_in/unit_in  4/2 ASCII chars, leftmost char in the top byte
//   busy              conversion in progress
//   done              one-cycle pulse, text_out updated in the same cycle
//   overflow          last completed conversion had value > 999999
//   text_out          {label, 6 digits MS-first, unit}, [95:88] leftmost

// Per-digit lane: double-dabble +3 correction and ASCII encoding of one nibble.
module cv_num2text_lane (
   input  logic [3:0] nib,
   input  logic       blank,
   input  logic       ovf,
   output logic [3:0] adj,
   output logic [7:0] chr
);
   assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;

   always_comb begin
      chr = {4'h3, nib};
      if (ovf)        chr = 8'h2D;
      else if (blank) chr = 8'h20;
   end
endmodule

module cv_num2text #(
   parameter int VALUE_W     = 20,
   parameter int BLANK_ZEROS = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               start,
   input  logic [VALUE_W-1:0] value,
   input  logic [31:0]        label_in,
   input  logic [15:0]        unit_in,
   output logic               busy,
   output logic               done,
   output logic               overflow,
   output logic [95:0]        text_out
);
   localparam int NUM_DIG = 6;
   localparam int CNT_W   = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

   typedef struct packed {
      logic [VALUE_W-1:0] value;
      logic [31:0]        label;
      logic [15:0]        unit;
   } req_t;

   state_t                         state, state_nxt;
   req_t                           shadow;
   logic [NUM_DIG-1:0][3:0]        bcd;      // [0] = least-significant digit
   logic [NUM_DIG-1:0][3:0]        adj;
   logic [NUM_DIG-1:0][7:0]        chr;
   logic [NUM_DIG*4-1:0]           adj_flat;
   logic [NUM_DIG-1:0]             zpfx;     // this digit and all above it are zero
   logic [NUM_DIG-1:0]             blank;
   logic [CNT_W-1:0]               cnt;
   logic                           ovf_pend;
   logic                           last_bit;
   logic                           ld, sh, fmt;

   assign last_bit = (cnt == CNT_W'(VALUE_W - 1));
   assign adj_flat = adj;

   genvar d;
   generate
      for (d = 0; d < NUM_DIG; d++) begin : g_dig
         if (d == NUM_DIG - 1) begin : g_top
            assign zpfx[d] = (bcd[d] == 4'd0);
         end else begin : g_low
            assign zpfx[d] = zpfx[d+1] & (bcd[d] == 4'd0);
         end
         // units digit is always shown
         assign blank[d] = (BLANK_ZEROS != 0) && (d != 0) && zpfx[d];

         cv_num2text_lane u_lane (
            .nib   (bcd[d]),
            .blank (blank[d]),
            .ovf   (ovf_pend),
            .adj   (adj[d]),
            .chr   (chr[d])
         );
      end
   endgenerate

   // state register + datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         shadow   <= '0;
         bcd      <= '0;
         cnt      <= '0;
         ovf_pend <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         text_out <= {12{8'h20}};
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
         done  <= fmt;
         if (ld) begin
            shadow   <= '{value: value, label: label_in, unit: unit_in};
            bcd      <= '0;
            cnt      <= '0;
            ovf_pend <= (64'(value) > 64'd999999);
         end
         if (sh) begin
            // corrected BCD shifted left, top bit dropped, value MSB shifted in
            bcd          <= {adj_flat[NUM_DIG*4-2:0], shadow.value[VALUE_W-1]};
            shadow.value <= shadow.value << 1;
            cnt          <= cnt + CNT_W'(1);
         end
         if (fmt) begin
            text_out <= {shadow.label, chr, shadow.unit};
            overflow <= ovf_pend;
         end
      end
   end

   // next state
   always_comb begin
      state_nxt = state;
      if (!en) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = FORMAT;
            FORMAT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // datapath strobes
   always_comb begin
      ld  = en && start && (state == IDLE);
      sh  = en && (state == SHIFT);
      fmt = en && (state == FORMAT);
   end
endmodule

// File: tb/tb_cv_num2text.sv
module tb_cv_num2text;
   logic        clk = 1'b0;
   logic        reset, en, start;
   logic [19:0] value;
   logic [31:0] label_in;
   logic [15:0] unit_in;
   logic        busy, done, overflow;
   logic [95:0] text_out;
   logic        busy0, done0, ovf0;
   logic [95:0] text0;

   int checks   = 0;
   int failures = 0;

   localparam logic [31:0] LBL_PW  = "PW: ";
   localparam logic [31:0] LBL_XX  = "XX: ";
   localparam logic [15:0] UNIT_US = "us";

   always #5 clk = ~clk;

   cv_num2text #(.VALUE_W(20), .BLANK_ZEROS(1)) dut (
      .clk(clk), .reset(reset), .en(en), .start(start), .value(value),
      .label_in(label_in), .unit_in(unit_in),
      .busy(busy), .done(done), .overflow(overflow), .text_out(text_out)
   );

   cv_num2text #(.VALUE_W(20), .BLANK_ZEROS(0)) dut0 (
      .clk(clk), .reset(reset), .en(en), .start(start), .value(value),
      .label_in(label_in), .unit_in(unit_in),
      .busy(busy0), .done(done0), .overflow(ovf0), .text_out(text0)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one cycle (cycle 0) and wait for done (bounded).
   // Returns the done cycle number (-1 on timeout) and a count of cycles
   // whose busy level was wrong.
   task automatic convert(input logic [19:0] v, input logic [31:0] lb,
                          input logic [15:0] un, output int dcyc, output int busy_bad);
      value = v; label_in = lb; unit_in = un; start = 1'b1;
      dcyc = -1; busy_bad = 0;
      for (int c = 1; c <= 40 && dcyc < 0; c++) begin
         step();
         start = 1'b0;
         if (done) begin
            dcyc = c;
            if (busy !== 1'b0) busy_bad++;
         end else if (busy !== 1'b1) busy_bad++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; en = 1'b0; start = 1'b0; value = '0;
      label_in = LBL_PW; unit_in = UNIT_US;
      step(); step();
      checks++;
      if ({busy, done, overflow} !== 3'b000) begin
         failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, overflow});
      end
      checks++;
      if (text_out !== {12{8'h20}}) begin
         failures++; $display("FAIL reset_text got=%h exp=%h", text_out, {12{8'h20}});
      end
      reset = 1'b0; en = 1'b1;
      step();
   endtask

   task automatic test_basic();
      int dc, bb;
      convert(20'd123456, LBL_PW, UNIT_US, dc, bb);
      checks++;
      if (dc !== 22) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=22", dc); end
      checks++;
      if (bb !== 0) begin failures++; $display("FAIL basic_busy bad_cycles=%0d exp=0", bb); end
      checks++;
      if (text_out !== 96'("PW: 123456us")) begin
         failures++; $display("FAIL basic_text got=%h exp=%h", text_out, 96'("PW: 123456us"));
      end
      checks++;
      if (overflow !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%b exp=0", overflow); end
      step();
      checks++;
      if (done !== 1'b0 || text_out !== 96'("PW: 123456us")) begin
         failures++; $display("FAIL basic_hold done=%b text=%h", done, text_out);
      end
   endtask

   task automatic test_zero();
      int dc, bb;
      convert(20'd0, LBL_PW, UNIT_US, dc, bb);
      checks++;
      if (dc !== 22 || done0 !== 1'b1) begin
         failures++; $display("FAIL zero_done got=%0d done0=%b exp=22 1", dc, done0);
      end
      checks++;
      if (text_out[63:16] !== 48'h202020202030) begin
         failures++; $display("FAIL zero_blank got=%h exp=202020202030", text_out[63:16]);
      end
      checks++;
      if (text0 !== 96'("PW: 000000us")) begin
         failures++; $display("FAIL zero_noblank got=%h exp=%h", text0, 96'("PW: 000000us"));
      end
   endtask

   task automatic test_values();
      int dc, bb;
      convert(20'd1050, LBL_PW, UNIT_US, dc, bb);
      checks++;
      if (dc !== 22 || text_out !== 96'("PW:   1050us")) begin
         failures++; $display("FAIL v1050 cyc=%0d got=%h exp=%h", dc, text_out, 96'("PW:   1050us"));
      end
      convert(20'd999999, LBL_PW, UNIT_US, dc, bb);
      checks++;
      if (dc !== 22 || text_out !== 96'("PW: 999999us") || overflow !== 1'b0) begin
         failures++; $display("FAIL v999999 cyc=%0d got=%h ovf=%b exp=%h ovf=0",
                              dc, text_out, overflow, 96'("PW: 999999us"));
      end
   endtask

   task automatic test_overflow();
      int dc, bb;
      convert(20'd1000000, LBL_PW, UNIT_US, dc, bb);
      checks++;
      if (dc !== 22 || text_out !== 96'("PW: ------us") || overflow !== 1'b1 || ovf0 !== 1'b1) begin
         failures++; $display("FAIL ovf_set cyc=%0d got=%h ovf=%b ovf0=%b exp=%h ovf=1",
                              dc, text_out, overflow, ovf0, 96'("PW: ------us"));
      end
      convert(20'd7, LBL_PW, UNIT_US, dc, bb);
      checks++;
      if (dc !== 22 || text_out !== 96'("PW:      7us") || overflow !== 1'b0) begin
         failures++; $display("FAIL ovf_clear cyc=%0d got=%h ovf=%b exp=%h ovf=0",
                              dc, text_out, overflow, 96'("PW:      7us"));
      end
   endtask

   task automatic test_start_while_busy();
      int dc = -1, ndone = 0, early = 0;
      value = 20'd42; label_in = LBL_PW; start = 1'b1;
      for (int c = 1; c <= 40 && dc < 0; c++) begin
         step();
         start = 1'b0;
         if (c == 5) begin start = 1'b1; value = 20'd99; label_in = LBL_XX; end
         if (done) dc = c;
         else if (text_out !== 96'("PW:      7us")) early++;
      end
      checks++;
      if (dc !== 22) begin failures++; $display("FAIL busy_start_cycle got=%0d exp=22", dc); end
      checks++;
      if (early !== 0) begin failures++; $display("FAIL busy_start_hold changed_cycles=%0d exp=0", early); end
      checks++;
      if (text_out !== 96'("PW:     42us")) begin
         failures++; $display("FAIL busy_start_text got=%h exp=%h", text_out, 96'("PW:     42us"));
      end
      for (int c = 0; c < 30; c++) begin step(); if (done) ndone++; end
      checks++;
      if (ndone !== 0) begin failures++; $display("FAIL busy_start_extra_done got=%0d exp=0", ndone); end
      label_in = LBL_PW;
   endtask

   task automatic test_back_to_back();
      int d1 = -1, d2 = -1;
      logic [95:0] t1 = '0, t2 = '0;
      value = 20'd5; start = 1'b1;
      for (int c = 1; c <= 60 && d2 < 0; c++) begin
         step();
         if (c == 1) value = 20'd6;
         if (done) begin
            if (d1 < 0) begin d1 = c; t1 = text_out; end
            else begin d2 = c; t2 = text_out; start = 1'b0; end
         end
      end
      start = 1'b0;
      checks++;
      if (d1 !== 22 || d2 !== 44) begin
         failures++; $display("FAIL b2b_cycles got=%0d,%0d exp=22,44", d1, d2);
      end
      checks++;
      if (t1 !== 96'("PW:      5us") || t2 !== 96'("PW:      6us")) begin
         failures++; $display("FAIL b2b_text got=%h,%h exp=%h,%h", t1, t2,
                              96'("PW:      5us"), 96'("PW:      6us"));
      end
      step();
   endtask

   task automatic test_en_drop();
      int dc, bb, ndone = 0;
      logic busy11 = 1'b1;
      convert(20'd1000000, LBL_PW, UNIT_US, dc, bb);
      step();
      en = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL en_low_start busy=%b exp=0", busy); end
      en = 1'b1; value = 20'd123456; start = 1'b1;
      for (int c = 1; c <= 35; c++) begin
         step();
         start = 1'b0;
         if (c == 10) en = 1'b0;
         if (c == 11) busy11 = busy;
         if (done) ndone++;
      end
      checks++;
      if (busy11 !== 1'b0) begin failures++; $display("FAIL en_drop_busy got=%b exp=0", busy11); end
      checks++;
      if (ndone !== 0 || text_out !== 96'("PW: ------us") || overflow !== 1'b1) begin
         failures++; $display("FAIL en_drop_hold dones=%0d text=%h ovf=%b exp=0 %h 1",
                              ndone, text_out, overflow, 96'("PW: ------us"));
      end
      en = 1'b1;
      step();
   endtask

   task automatic test_reset_mid();
      int ndone = 0;
      value = 20'd123456; start = 1'b1;
      for (int c = 1; c <= 35; c++) begin
         step();
         start = 1'b0;
         if (c == 10) reset = 1'b1;
         if (c == 11) begin
            reset = 1'b0;
            checks++;
            if (text_out !== {12{8'h20}} || busy !== 1'b0 || overflow !== 1'b0) begin
               failures++; $display("FAIL reset_mid_state text=%h busy=%b ovf=%b exp=%h 0 0",
                                    text_out, busy, overflow, {12{8'h20}});
            end
         end
         if (done) ndone++;
      end
      checks++;
      if (ndone !== 0) begin failures++; $display("FAIL reset_mid_done got=%0d exp=0", ndone); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_values();
      test_overflow();
      test_start_while_busy();
      test_back_to_back();
      test_en_drop();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
